// File: rtl/instr_pack.sv
// Shared definitions for the 9-bit CPU control path: sequencer states and
// default subroutine entry-point layout.
package instr_pack;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } seq_state_t;

  localparam int SR_BASE_DEF   = 100;
  localparam int SR_STRIDE_DEF = 16;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decoder <-> sequencer bundle: decoded control requests in, pc and run status out.
interface pc_sequencer_if #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               start;
    logic               stall;
    logic               br_req;
    logic               br_taken;
    logic [7:0]         br_target;
    logic               call_req;
    logic [3:0]         call_idx;
    logic               ret_req;
    logic               done_req;
    logic [PC_W-1:0]    pc;
    logic               run;
    logic               done;
    logic               fault;
    logic [DEPTH_W-1:0] depth;

    modport master (
        output start, stall, br_req, br_taken, br_target,
               call_req, call_idx, ret_req, done_req,
        input  pc, run, done, fault, depth
    );

    modport slave (
        input  start, stall, br_req, br_taken, br_target,
               call_req, call_idx, ret_req, done_req,
        output pc, run, done, fault, depth
    );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Hardware LIFO of return addresses; dout is the current top of stack.
// The caller guarantees push and pop are never asserted together.
module return_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] depth_q, depth_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        depth_d = depth_q;
        mem_d   = mem_q;
        if (clear) begin
            depth_d = '0;
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (depth_q == CNT_W'(i)) mem_d[i] = din;
            end
            depth_d = depth_q + CNT_W'(1);
        end else if (pop) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == CNT_W'(i + 1)) dout = mem_q[i];
        end
    end

    assign full  = (depth_q == CNT_W'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= '0;
            // NOTE: the stack is tiny, so its entries are reset too and dout is never X.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Program counter and control-flow FSM: sequential fetch, branch, call/return
// through a hardware return stack, done and stack-fault status.
module pc_sequencer
    import instr_pack::*;
#(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int SR_BASE     = SR_BASE_DEF,
    parameter int SR_STRIDE   = SR_STRIDE_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    pc_sequencer_if.slave  bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    seq_state_t         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               run_q, run_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;

    logic               stk_push, stk_pop, stk_clear;
    logic               stk_full, stk_empty;
    logic [PC_W-1:0]    stk_dout;
    logic [DEPTH_W-1:0] stk_depth;

    logic [PC_W-1:0]    pc_inc, call_addr;

    // Both wrap modulo 2**PC_W by construction.
    assign pc_inc    = pc_q + PC_W'(1);
    assign call_addr = PC_W'(SR_BASE) + PC_W'(bus.call_idx) * PC_W'(SR_STRIDE);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clear = 1'b0;
        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    if (bus.done_req) begin
                        state_d = DONE;
                    end else if (bus.ret_req) begin
                        if (stk_empty) begin
                            state_d = FAULT;
                        end else begin
                            stk_pop = 1'b1;
                            pc_d    = stk_dout;
                        end
                    end else if (bus.call_req) begin
                        if (stk_full) begin
                            state_d = FAULT;
                        end else begin
                            stk_push = 1'b1;
                            pc_d     = call_addr;
                        end
                    end else if (bus.br_req && bus.br_taken) begin
                        pc_d = PC_W'(bus.br_target);
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                // IDLE, DONE and FAULT all restart the program from address 0.
                if (bus.start) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    stk_clear = 1'b1;
                end
            end
        endcase
        run_d   = (state_d == RUN);
        done_d  = (state_d == DONE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= run_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    return_stack #(
        .WIDTH (PC_W),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (stk_clear),
        .push    (stk_push),
        .pop     (stk_pop),
        .din     (pc_inc),
        .dout    (stk_dout),
        .full    (stk_full),
        .empty   (stk_empty),
        .depth   (stk_depth)
    );

    assign bus.pc    = pc_q;
    assign bus.run   = run_q;
    assign bus.done  = done_q;
    assign bus.fault = fault_q;
    assign bus.depth = stk_depth;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of per-cycle vectors plus
// hand-written sequences for done-hold, restart, pc wrap and async reset.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(10), .STACK_DEPTH(4)) bus ();

    pc_sequencer #(
        .PC_W        (10),
        .STACK_DEPTH (4),
        .SR_BASE     (100),
        .SR_STRIDE   (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic       start;
        logic       stall;
        logic       br_req;
        logic       br_taken;
        logic [7:0] br_target;
        logic       call_req;
        logic [3:0] call_idx;
        logic       ret_req;
        logic       done_req;
        logic [9:0] exp_pc;
        logic       exp_run;
        logic       exp_done;
        logic       exp_fault;
        logic [2:0] exp_depth;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic br, input logic tk,
                         input logic [7:0] tgt, input logic cl, input logic [3:0] idx,
                         input logic rt, input logic dn);
        bus.start     = st;
        bus.stall     = sl;
        bus.br_req    = br;
        bus.br_taken  = tk;
        bus.br_target = tgt;
        bus.call_req  = cl;
        bus.call_idx  = idx;
        bus.ret_req   = rt;
        bus.done_req  = dn;
    endtask

    task automatic check_status(input string tag, input logic [9:0] pc, input logic run,
                                input logic dn, input logic ft, input logic [2:0] dp);
        check({tag, " pc"},    32'(bus.pc),    32'(pc));
        check({tag, " run"},   32'(bus.run),   32'(run));
        check({tag, " done"},  32'(bus.done),  32'(dn));
        check({tag, " fault"}, 32'(bus.fault), 32'(ft));
        check({tag, " depth"}, 32'(bus.depth), 32'(dp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_pc;

        //          st sl br tk tgt   cl idx rt dn   pc  run dn ft dp
        vecs[0]  = '{1, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd0,   1, 0, 0, 3'd0};
        vecs[1]  = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd1,   1, 0, 0, 3'd0};
        vecs[2]  = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd2,   1, 0, 0, 3'd0};
        vecs[3]  = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd3,   1, 0, 0, 3'd0};
        vecs[4]  = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd4,   1, 0, 0, 3'd0};
        vecs[5]  = '{0, 0, 1, 1, 8'd92,  0, 4'd0,  0, 0, 10'd92,  1, 0, 0, 3'd0};
        vecs[6]  = '{0, 0, 1, 1, 8'd9,   0, 4'd0,  0, 0, 10'd9,   1, 0, 0, 3'd0};
        vecs[7]  = '{0, 0, 1, 1, 8'd92,  0, 4'd0,  0, 0, 10'd92,  1, 0, 0, 3'd0};
        vecs[8]  = '{0, 0, 1, 0, 8'd9,   0, 4'd0,  0, 0, 10'd93,  1, 0, 0, 3'd0};
        vecs[9]  = '{0, 0, 1, 1, 8'd44,  0, 4'd0,  0, 0, 10'd44,  1, 0, 0, 3'd0};
        vecs[10] = '{0, 0, 0, 0, 8'd0,   1, 4'd0,  0, 0, 10'd100, 1, 0, 0, 3'd1};
        vecs[11] = '{0, 0, 1, 1, 8'd112, 0, 4'd0,  0, 0, 10'd112, 1, 0, 0, 3'd1};
        vecs[12] = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  1, 0, 10'd45,  1, 0, 0, 3'd0};
        vecs[13] = '{0, 0, 0, 0, 8'd0,   1, 4'd2,  0, 0, 10'd132, 1, 0, 0, 3'd1};
        // ret beats call and branch when all are requested together
        vecs[14] = '{0, 0, 1, 1, 8'd7,   1, 4'd3,  1, 0, 10'd46,  1, 0, 0, 3'd0};
        vecs[15] = '{0, 0, 1, 1, 8'd50,  0, 4'd0,  0, 0, 10'd50,  1, 0, 0, 3'd0};
        vecs[16] = '{0, 1, 0, 0, 8'd0,   1, 4'd1,  0, 0, 10'd50,  1, 0, 0, 3'd0};
        vecs[17] = '{0, 1, 0, 0, 8'd0,   1, 4'd1,  0, 0, 10'd50,  1, 0, 0, 3'd0};
        vecs[18] = '{0, 1, 0, 0, 8'd0,   1, 4'd1,  0, 0, 10'd50,  1, 0, 0, 3'd0};
        // call beats a taken branch
        vecs[19] = '{0, 0, 1, 1, 8'd7,   1, 4'd1,  0, 0, 10'd116, 1, 0, 0, 3'd1};
        vecs[20] = '{0, 0, 0, 0, 8'd0,   1, 4'd3,  0, 0, 10'd148, 1, 0, 0, 3'd2};
        vecs[21] = '{0, 0, 0, 0, 8'd0,   1, 4'd15, 0, 0, 10'd340, 1, 0, 0, 3'd3};
        vecs[22] = '{0, 0, 0, 0, 8'd0,   1, 4'd0,  0, 0, 10'd100, 1, 0, 0, 3'd4};
        vecs[23] = '{0, 0, 0, 0, 8'd0,   1, 4'd5,  0, 0, 10'd100, 0, 0, 1, 3'd4};
        vecs[24] = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd100, 0, 0, 1, 3'd4};
        vecs[25] = '{1, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd0,   1, 0, 0, 3'd0};
        vecs[26] = '{0, 0, 0, 0, 8'd0,   0, 4'd0,  1, 0, 10'd0,   0, 0, 1, 3'd0};
        vecs[27] = '{1, 0, 0, 0, 8'd0,   0, 4'd0,  0, 0, 10'd0,   1, 0, 0, 3'd0};
        vecs[28] = '{0, 0, 1, 1, 8'd93,  0, 4'd0,  0, 0, 10'd93,  1, 0, 0, 3'd0};
        // done beats call
        vecs[29] = '{0, 0, 0, 0, 8'd0,   1, 4'd1,  0, 1, 10'd93,  0, 1, 0, 3'd0};

        drive(0, 0, 0, 0, 8'd0, 0, 4'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_status("reset", 10'd0, 1'b0, 1'b0, 1'b0, 3'd0);

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].start, vecs[i].stall, vecs[i].br_req, vecs[i].br_taken,
                  vecs[i].br_target, vecs[i].call_req, vecs[i].call_idx,
                  vecs[i].ret_req, vecs[i].done_req);
            step();
            check_status($sformatf("row%0d", i), vecs[i].exp_pc, vecs[i].exp_run,
                         vecs[i].exp_done, vecs[i].exp_fault, vecs[i].exp_depth);
        end

        // DONE holds pc with no requests pending
        drive(0, 0, 0, 0, 8'd0, 0, 4'd0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("done_hold%0d pc", k), 32'(bus.pc), 32'd93);
            check($sformatf("done_hold%0d done", k), 32'(bus.done), 32'd1);
        end

        drive(1, 0, 0, 0, 8'd0, 0, 4'd0, 0, 0);
        step();
        check_status("restart", 10'd0, 1'b1, 1'b0, 1'b0, 3'd0);
        step();
        check("start_in_run pc1", 32'(bus.pc), 32'd1);
        step();
        check("start_in_run pc2", 32'(bus.pc), 32'd2);

        // sequential fetch across the top of the address space
        drive(0, 0, 1, 1, 8'd255, 0, 4'd0, 0, 0);
        step();
        check("wrap base pc", 32'(bus.pc), 32'd255);
        drive(0, 0, 0, 0, 8'd0, 0, 4'd0, 0, 0);
        exp_pc = 10'd255;
        for (int k = 0; k < 768; k++) begin
            step();
            exp_pc = exp_pc + 10'd1;
        end
        check("wrap top pc", 32'(bus.pc), 32'(exp_pc));
        check("wrap top expect", 32'(exp_pc), 32'd1023);
        step();
        check("wrap zero pc", 32'(bus.pc), 32'd0);

        // async reset mid-run with a non-empty stack
        drive(0, 0, 0, 0, 8'd0, 1, 4'd0, 0, 0);
        step();
        check_status("pre_reset call", 10'd100, 1'b1, 1'b0, 1'b0, 3'd1);
        drive(0, 0, 1, 1, 8'd37, 0, 4'd0, 0, 0);
        step();
        check("pre_reset pc", 32'(bus.pc), 32'd37);
        drive(0, 0, 0, 0, 8'd0, 0, 4'd0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_status("async_reset", 10'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check_status("idle_after_reset", 10'd0, 1'b0, 1'b0, 1'b0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and control-flow controller for the 9-bit CPU. It drives the `pc` address into `instr_memory` and advances or redirects it from decoded control requests: branch-if-nonzero, subroutine call and return, done, and pipeline stall. It owns a small hardware return stack and the run/done/fault status. It sits between the instruction decoder and `instr_memory`, and is the only block that writes `pc`.

## Interface
Parameters:
- `PC_W`, 10: program counter width; `instr_memory` depth is 2**PC_W.
- `STACK_DEPTH`, 4: return-stack entries.
- `SR_BASE`, 100: address of subroutine 0.
- `SR_STRIDE`, 16: address spacing between subroutine entry points.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin or restart execution at address 0.
- `stall`  in  1  hold `pc` this cycle; ignore all requests.
- `br_req`  in  1  decoded `bnzr`.
- `br_taken`  in  1  tested register is nonzero; qualifies `br_req`.
- `br_target`  in  8  branch target from register z, zero-extended to PC_W.
- `call_req`  in  1  decoded `jtsr`.
- `call_idx`  in  4  subroutine index.
- `ret_req`  in  1  decoded `rfsr`.
- `done_req`  in  1  decoded `func done`.
- `pc`  out  PC_W  instruction address.
- `run`  out  1  state is RUN; decoder may execute `instr`.
- `done`  out  1  program finished.
- `fault`  out  1  return-stack overflow or underflow.
- `depth`  out  $clog2(STACK_DEPTH+1)  current return-stack occupancy.

## Operation
States:
- **IDLE** (reset state):
  - `start` → RUN.
  - `pc` stays 0.
- **RUN**: see update rules below.
- **DONE**:
  - `pc` frozen at the address of the done instruction.
  - `done` = 1, `run` = 0.
- **FAULT**:
  - `pc` frozen at the faulting instruction.
  - `fault` = 1, `run` = 0.

Leaving DONE or FAULT:
- `start` → RUN, with `pc` = 0, `depth` = 0, and `done`/`fault` cleared.
- `start` is ignored while in RUN.

RUN update rules (apply when `stall` = 0, in priority order; multiple asserted requests resolve by this order):
1. `done_req` → DONE.
2. `ret_req`:
   - depth = 0 → FAULT.
   - Otherwise pop; `pc` ← top of stack.
3. `call_req`:
   - depth = STACK_DEPTH → FAULT.
   - Otherwise push `pc`+1 (mod 2**PC_W); `pc` ← SR_BASE + `call_idx`·SR_STRIDE, truncated to PC_W.
4. `br_req` && `br_taken` → `pc` ← {0, `br_target`}.
5. Otherwise `pc` ← `pc`+1. Wraps 2**PC_W−1 → 0.

Additional rules:
- `br_req` with `br_taken` = 0 falls through to rule 5.
- `stall` = 1 in RUN: `pc`, stack and state all hold; every request is ignored that cycle.

## Timing
- Reset values: `pc` = 0, state IDLE, `run` = 0, `done` = 0, `fault` = 0, `depth` = 0, stack contents cleared.
- Reset asserted mid-operation:
  - Immediate and asynchronous return to reset values.
  - The stack is discarded.
- `instr_memory` read is combinational. The instruction at `pc` is decoded in the same cycle, and the new `pc` appears one cycle later, so every instruction takes 1 cycle.
- `start` in IDLE, DONE or FAULT: `run` = 1 from the next edge, with `pc` = 0.
- `done` and `fault` are registered and assert on the edge that takes their request.
- `depth` updates on the same edge as the push or pop.

## Structure
- Add to `instr_pack`:
  - `seq_state_t` enum {IDLE, RUN, DONE, FAULT}.
  - Default constants `SR_BASE_DEF` and `SR_STRIDE_DEF`.
- Sub-module `return_stack`: parameterised LIFO.
  - Ports: `push`, `pop`, `din`, `dout` (top of stack), `full`, `empty`, `depth`; asynchronous active-low reset.
  - Simultaneous push and pop never occurs, because the priority logic in `pc_sequencer` excludes it.

## Test plan
- Reset and sequential fetch:
  - Reset → `pc` = 0, all status outputs 0.
  - `start` pulse → `pc` = 0,1,2,3,4 on successive edges with `run` = 1.
  - Assert `reset_n` low at `pc` = 37 → `pc` = 0 immediately, IDLE.
- Branch:
  - At `pc` = 92, `br_req`=1, `br_taken`=1, `br_target`=9 → next `pc` = 9.
  - Repeat with `br_taken`=0 → next `pc` = 93.
- Call and return:
  - At `pc` = 44, `call_idx`=0 → `pc` = 100, `depth` = 1.
  - At `pc` = 112, `ret_req` → `pc` = 45, `depth` = 0.
  - `call_idx` = 2 → `pc` = 132.
- Stack faults:
  - Four nested calls → `depth` = 4; a fifth call → FAULT, `pc` held, `fault` = 1.
  - After a restart, `ret_req` at `depth` = 0 → FAULT.
- Stall and wrap:
  - `stall` held 3 cycles with `call_req` asserted at `pc` = 50 → `pc` stays 50, `depth` unchanged.
  - At `pc` = 1023 with no request → `pc` = 0.
- Done and restart:
  - `done_req` at `pc` = 93 → `done` = 1, `run` = 0, `pc` stays 93 for 10 cycles.
  - `start` → `pc` = 0, `done` = 0, `run` = 1.
  - `start` while in RUN → no effect.
